s_term_single_frame_select: RTL and testbench

- South termination tile for a fabric column: the bottom-edge counterpart of the north termination tile.
- Loops every southbound routing wire arriving at the bottom edge back onto the matching northbound wire.
- Ties off the carry chain.
- Hosts the column's frame-select logic: decodes frame addresses from the configuration controller and drives a registered one-hot FrameStrobe up the column, with a ready/valid handshake.

---
 rtl/s_term_single_frame_select_pkg.sv | 41 ++++
 rtl/s_term_single_frame_select_decoder.sv | 34 +++
 rtl/s_term_single_frame_select.sv | 132 +++++++++++++
 tb/tb_s_term_single_frame_select.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/s_term_single_frame_select_pkg.sv
// Shared definitions for the south termination tile frame-select logic.
// Holds the frame-address field layout, the frame-select FSM state type,
// and the one-hot frame decode with range check.
package s_term_single_frame_select_pkg;

    // FrameAddress layout: {unused, column field, frame field}
    localparam int unsigned FRAME_ADDR_W        = 32;
    localparam int unsigned FRAME_FIELD_LSB     = 0;
    localparam int unsigned DEFAULT_FRAME_SEL_W = 5;
    localparam int unsigned DEFAULT_COL_SEL_W   = 5;

    // Strobe hold counter covers StrobeCycles-1 for StrobeCycles in 1..15
    localparam int unsigned STROBE_CNT_W = 4;

    // Upper bound on the frame vector the decode function can produce
    localparam int unsigned MAX_FRAMES_LIMIT = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STROBE,
        ST_GAP
    } fs_state_t;

    typedef struct packed {
        logic                        in_range;
        logic [MAX_FRAMES_LIMIT-1:0] onehot;
    } frame_decode_t;

    // One-hot decode of an unsigned frame index; out-of-range indices give
    // an all-zero vector so the strobe can never carry a stray bit.
    function automatic frame_decode_t frame_onehot(
        input logic [FRAME_ADDR_W-1:0] frame,
        input int unsigned             max_frames
    );
        frame_decode_t d;
        d.in_range = (frame < max_frames);
        d.onehot   = d.in_range ? (MAX_FRAMES_LIMIT'(1) << frame[4:0]) : '0;
        return d;
    endfunction

endpackage

// File: rtl/s_term_single_frame_select_decoder.sv
// frame_select_decoder: combinational frame-address decode.
// Ports:
//   i_field      - column and frame fields of FrameAddress
//   o_col_match  - column field equals ColumnId
//   o_in_range   - frame field < MaxFramesPerCol (unsigned)
//   o_onehot     - 1 << frame when in range, else zero
module frame_select_decoder
    import s_term_single_frame_select_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol  = 20,
    parameter int unsigned FrameSelectWidth = DEFAULT_FRAME_SEL_W,
    parameter int unsigned ColSelectWidth   = DEFAULT_COL_SEL_W,
    parameter int unsigned ColumnId         = 0
) (
    input  logic [FrameSelectWidth+ColSelectWidth-1:0] i_field,
    output logic                                       o_col_match,
    output logic                                       o_in_range,
    output logic [MaxFramesPerCol-1:0]                 o_onehot
);

    logic [FrameSelectWidth-1:0] w_frame;
    logic [ColSelectWidth-1:0]   w_col;
    frame_decode_t               w_dec;

    always_comb begin
        w_frame     = i_field[FRAME_FIELD_LSB +: FrameSelectWidth];
        w_col       = i_field[FrameSelectWidth +: ColSelectWidth];
        w_dec       = frame_onehot(FRAME_ADDR_W'(w_frame), MaxFramesPerCol);
        o_col_match = (w_col == ColSelectWidth'(ColumnId));
        o_in_range  = w_dec.in_range;
        o_onehot    = w_dec.onehot[MaxFramesPerCol-1:0];
    end

endmodule

// File: rtl/s_term_single_frame_select.sv
// s_term_single_frame_select: south termination tile of a fabric column.
// Loops southbound wires back northbound, ties off the carry chain, and
// issues registered one-hot FrameStrobe pulses from decoded frame addresses.
// Ports:
//   CLK, reset                - config clock, async active-high reset
//   S1END/S2MID/S2END/S4END   - southbound wires arriving at the edge
//   N1BEG/N2BEG/N2BEGb/N4BEG  - northbound loopback of the above
//   Co                        - carry-in of bottom logic tile (tied 0)
//   FrameAddress/Valid/Ready  - frame address handshake
//   FrameStrobe               - one-hot frame strobe up the column
//   FrameError                - one-cycle pulse on out-of-range frame
module s_term_single_frame_select
    import s_term_single_frame_select_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol  = 20,
    parameter int unsigned FrameSelectWidth = DEFAULT_FRAME_SEL_W,
    parameter int unsigned ColSelectWidth   = DEFAULT_COL_SEL_W,
    parameter int unsigned ColumnId         = 0,
    parameter int unsigned StrobeCycles     = 1
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [3:0]                 S1END,
    input  logic [7:0]                 S2MID,
    input  logic [7:0]                 S2END,
    input  logic [15:0]                S4END,
    output logic [3:0]                 N1BEG,
    output logic [7:0]                 N2BEG,
    output logic [7:0]                 N2BEGb,
    output logic [15:0]                N4BEG,
    output logic                       Co,
    input  logic [FRAME_ADDR_W-1:0]    FrameAddress,
    input  logic                       FrameAddressValid,
    output logic                       FrameAddressReady,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       FrameError
);

    localparam logic [STROBE_CNT_W-1:0] CNT_LOAD = STROBE_CNT_W'(StrobeCycles - 1);

    fs_state_t                   r_state;
    fs_state_t                   w_state_next;
    logic [STROBE_CNT_W-1:0]     r_count;
    logic [STROBE_CNT_W-1:0]     w_count_next;
    logic [MaxFramesPerCol-1:0]  r_strobe;
    logic [MaxFramesPerCol-1:0]  w_strobe_next;
    logic                        r_error;
    logic                        w_error_next;

    logic                        w_col_match;
    logic                        w_in_range;
    logic [MaxFramesPerCol-1:0]  w_onehot;
    logic                        w_accept;

    // Routing loopback and carry tie-off
    assign N1BEG  = S1END;
    assign N2BEG  = S2MID;
    assign N2BEGb = S2END;
    assign N4BEG  = S4END;
    assign Co     = 1'b0;

    frame_select_decoder #(
        .MaxFramesPerCol (MaxFramesPerCol),
        .FrameSelectWidth(FrameSelectWidth),
        .ColSelectWidth  (ColSelectWidth),
        .ColumnId        (ColumnId)
    ) u_decoder (
        .i_field    (FrameAddress[FrameSelectWidth+ColSelectWidth-1:0]),
        .o_col_match(w_col_match),
        .o_in_range (w_in_range),
        .o_onehot   (w_onehot)
    );

    // Ready is only high in IDLE, so accept is Valid qualified by IDLE
    assign w_accept = FrameAddressValid && (r_state == ST_IDLE);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_strobe <= '0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_strobe <= w_strobe_next;
            r_error  <= w_error_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_accept && w_col_match && w_in_range) w_state_next = ST_STROBE;
            ST_STROBE: if (r_count == '0) w_state_next = ST_GAP;
            ST_GAP:    w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs plus the combinational Ready
    always_comb begin
        w_count_next  = r_count;
        w_strobe_next = r_strobe;
        w_error_next  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_strobe_next = '0;
                if (w_accept && w_col_match) begin
                    if (w_in_range) begin
                        w_strobe_next = w_onehot;
                        w_count_next  = CNT_LOAD;
                    end else begin
                        w_error_next = 1'b1;
                    end
                end
            end
            ST_STROBE: begin
                if (r_count == '0) w_strobe_next = '0;
                else               w_count_next  = r_count - 1'b1;
            end
            default: begin
                w_strobe_next = '0;
            end
        endcase
    end

    assign FrameAddressReady = (r_state == ST_IDLE);
    assign FrameStrobe       = r_strobe;
    assign FrameError        = r_error;

endmodule

// File: tb/tb_s_term_single_frame_select.sv
module tb_s_term_single_frame_select;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  s1end = '0;
    logic [7:0]  s2mid = '0;
    logic [7:0]  s2end = '0;
    logic [15:0] s4end = '0;

    // DUT with StrobeCycles=1
    logic [3:0]  n1beg_1;
    logic [7:0]  n2beg_1, n2begb_1;
    logic [15:0] n4beg_1;
    logic        co_1;
    logic [31:0] fa1 = '0;
    logic        fv1 = 1'b0;
    logic        rdy1;
    logic [19:0] strobe1;
    logic        err1;

    // DUT with StrobeCycles=3
    logic [3:0]  n1beg_3;
    logic [7:0]  n2beg_3, n2begb_3;
    logic [15:0] n4beg_3;
    logic        co_3;
    logic [31:0] fa3 = '0;
    logic        fv3 = 1'b0;
    logic        rdy3;
    logic [19:0] strobe3;
    logic        err3;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    s_term_single_frame_select #(
        .MaxFramesPerCol(20), .FrameSelectWidth(5), .ColSelectWidth(5),
        .ColumnId(0), .StrobeCycles(1)
    ) u_dut1 (
        .CLK(CLK), .reset(reset),
        .S1END(s1end), .S2MID(s2mid), .S2END(s2end), .S4END(s4end),
        .N1BEG(n1beg_1), .N2BEG(n2beg_1), .N2BEGb(n2begb_1), .N4BEG(n4beg_1),
        .Co(co_1),
        .FrameAddress(fa1), .FrameAddressValid(fv1), .FrameAddressReady(rdy1),
        .FrameStrobe(strobe1), .FrameError(err1)
    );

    s_term_single_frame_select #(
        .MaxFramesPerCol(20), .FrameSelectWidth(5), .ColSelectWidth(5),
        .ColumnId(0), .StrobeCycles(3)
    ) u_dut3 (
        .CLK(CLK), .reset(reset),
        .S1END(s1end), .S2MID(s2mid), .S2END(s2end), .S4END(s4end),
        .N1BEG(n1beg_3), .N2BEG(n2beg_3), .N2BEGb(n2begb_3), .N4BEG(n4beg_3),
        .Co(co_3),
        .FrameAddress(fa3), .FrameAddressValid(fv3), .FrameAddressReady(rdy3),
        .FrameStrobe(strobe3), .FrameError(err3)
    );

    function automatic logic [31:0] mk_addr(input int unsigned col, input int unsigned frame);
        return 32'((col << 5) | frame);
    endfunction

    task automatic test_reset;
        s1end = 4'hA; s2mid = 8'h5C; s2end = 8'hC3; s4end = 16'hBEEF;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++; if (n1beg_1 !== 4'hA) begin errors++; $display("FAIL rst_n1beg: got %h want a", n1beg_1); end
            checks++; if (n2beg_1 !== 8'h5C) begin errors++; $display("FAIL rst_n2beg: got %h want 5c", n2beg_1); end
            checks++; if (n2begb_1 !== 8'hC3) begin errors++; $display("FAIL rst_n2begb: got %h want c3", n2begb_1); end
            checks++; if (n4beg_1 !== 16'hBEEF) begin errors++; $display("FAIL rst_n4beg: got %h want beef", n4beg_1); end
            checks++; if (co_1 !== 1'b0 || co_3 !== 1'b0) begin errors++; $display("FAIL rst_co: got %b/%b want 0/0", co_1, co_3); end
            checks++; if (n4beg_3 !== 16'hBEEF || n1beg_3 !== 4'hA) begin errors++; $display("FAIL rst_loop3: got %h/%h want beef/a", n4beg_3, n1beg_3); end
            checks++; if (rdy1 !== 1'b1 || rdy3 !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b/%b want 1/1", rdy1, rdy3); end
            checks++; if (strobe1 !== 20'h0 || strobe3 !== 20'h0) begin errors++; $display("FAIL rst_strobe: got %h/%h want 0/0", strobe1, strobe3); end
            checks++; if (err1 !== 1'b0 || err3 !== 1'b0) begin errors++; $display("FAIL rst_error: got %b/%b want 0/0", err1, err3); end
            @(posedge CLK);
        end
        @(negedge CLK);
        reset = 1'b0;
        #1;
        checks++; if (n2beg_1 !== 8'h5C || n2begb_1 !== 8'hC3 || n4beg_1 !== 16'hBEEF) begin
            errors++; $display("FAIL post_rst_loop: got %h %h %h want 5c c3 beef", n2beg_1, n2begb_1, n4beg_1); end
        s1end = 4'h3; s4end = 16'h1234;
        #1;
        checks++; if (n1beg_1 !== 4'h3 || n4beg_3 !== 16'h1234) begin
            errors++; $display("FAIL loop_change: got %h %h want 3 1234", n1beg_1, n4beg_3); end
    endtask

    task automatic test_single;
        logic [19:0] exp_s [0:3];
        logic        exp_r [0:3];
        exp_s = '{20'h00080, 20'h00000, 20'h00000, 20'h00000};
        exp_r = '{1'b0, 1'b0, 1'b1, 1'b1};
        @(posedge CLK); #1;
        fa1 = mk_addr(0, 7); fv1 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK); #1;
            fv1 = 1'b0; fa1 = '0;
            checks++; if (strobe1 !== exp_s[c]) begin errors++; $display("FAIL single_strobe[%0d]: got %h want %h", c, strobe1, exp_s[c]); end
            checks++; if (rdy1 !== exp_r[c]) begin errors++; $display("FAIL single_ready[%0d]: got %b want %b", c, rdy1, exp_r[c]); end
            checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL single_error[%0d]: got %b want 0", c, err1); end
        end
    endtask

    task automatic test_back_to_back;
        logic [19:0] exp_s [0:15];
        logic        exp_r [0:15];
        int unsigned next_frame [0:15];
        exp_s = '{20'h00001, 20'h00001, 20'h00001, 20'h00000, 20'h00000,
                  20'h00002, 20'h00002, 20'h00002, 20'h00000, 20'h00000,
                  20'h80000, 20'h80000, 20'h80000, 20'h00000, 20'h00000,
                  20'h00000};
        exp_r = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b1};
        // Address presented for the edge after observation c; frames 5, 9, 11
        // only ever appear while Ready is low and must never strobe.
        next_frame = '{5, 5, 5, 5, 1, 9, 9, 9, 9, 19, 11, 11, 11, 11, 0, 0};
        @(posedge CLK); #1;
        fa3 = mk_addr(0, 0); fv3 = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(posedge CLK); #1;
            fa3 = mk_addr(0, next_frame[c]);
            if (c >= 14) fv3 = 1'b0;
            checks++; if (strobe3 !== exp_s[c]) begin errors++; $display("FAIL b2b_strobe[%0d]: got %h want %h", c, strobe3, exp_s[c]); end
            checks++; if (rdy3 !== exp_r[c]) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", c, rdy3, exp_r[c]); end
            checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL b2b_error[%0d]: got %b want 0", c, err3); end
        end
    endtask

    task automatic test_error;
        @(posedge CLK); #1;
        fa1 = mk_addr(0, 25); fv1 = 1'b1;
        @(posedge CLK); #1;
        fv1 = 1'b0;
        checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL oor_error: got %b want 1", err1); end
        checks++; if (strobe1 !== 20'h0) begin errors++; $display("FAIL oor_strobe: got %h want 0", strobe1); end
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL oor_ready: got %b want 1", rdy1); end
        @(posedge CLK); #1;
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL oor_error_end: got %b want 0", err1); end
        checks++; if (strobe1 !== 20'h0 || rdy1 !== 1'b1) begin errors++; $display("FAIL oor_after: got %h/%b want 0/1", strobe1, rdy1); end
        fa1 = mk_addr(4, 3); fv1 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            fv1 = 1'b0;
            checks++; if (strobe1 !== 20'h0) begin errors++; $display("FAIL othercol_strobe[%0d]: got %h want 0", c, strobe1); end
            checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL othercol_ready[%0d]: got %b want 1", c, rdy1); end
            checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL othercol_error[%0d]: got %b want 0", c, err1); end
        end
    endtask

    task automatic test_async_reset;
        @(posedge CLK); #1;
        fa3 = mk_addr(0, 2); fv3 = 1'b1;
        @(posedge CLK); #1;
        fv3 = 1'b0;
        checks++; if (strobe3 !== 20'h00004) begin errors++; $display("FAIL arst_first: got %h want 00004", strobe3); end
        @(posedge CLK); #1;
        checks++; if (strobe3 !== 20'h00004) begin errors++; $display("FAIL arst_second: got %h want 00004", strobe3); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (strobe3 !== 20'h0) begin errors++; $display("FAIL arst_clear: got %h want 0", strobe3); end
        checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b want 1", rdy3); end
        @(negedge CLK);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge CLK); #1;
            checks++; if (strobe3 !== 20'h0) begin errors++; $display("FAIL arst_noreissue[%0d]: got %h want 0", c, strobe3); end
            checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL arst_idle_ready[%0d]: got %b want 1", c, rdy3); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_error();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
